// File: rtl/dmem_lsu.sv
// dmem_lsu: single-port data memory with an RV32I load/store unit.
// One access at a time: IDLE accepts, WAIT burns WAIT_STATES cycles, RESP
// commits stores / captures loads and raises rsp_valid on the next cycle.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being force-aligned.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  logic [31:0]   mem [DEPTH_WORDS] = '{default: 32'h0000_0008};

  logic [AW-1:0] widx;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [31:0]   wr_data;
  logic [31:0]   ld_val;
  logic [3:0]    be;
  logic [1:0]    off;
  logic          illegal;
  logic          err;

  assign widx    = addr_q[AW+1:2];
  assign rd_word = mem[widx];

  // Size decode: byte lane offset, byte enables, replicated store data, load extraction.
  always_comb begin
    be      = '0;
    wr_data = '0;
    ld_val  = '0;
    illegal = 1'b0;
    off     = addr_q[1:0];
    case (f3_q)
      3'b000, 3'b100: begin
        be      = 4'b0001 << off;
        wr_data = {4{wdata_q[7:0]}};
      end
      3'b001, 3'b101: begin
        off     = {addr_q[1], 1'b0};
        be      = 4'b0011 << off;
        wr_data = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        off     = 2'b00;
        be      = 4'b1111;
        wr_data = wdata_q;
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (we_q && f3_q[2]) illegal = 1'b1;
    shifted = rd_word >> {off, 3'b000};
    case (f3_q)
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_val = {24'h0, shifted[7:0]};
      3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_val = {16'h0, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  // Misaligned half (addr[0]) or word (addr[1:0]) accesses raise a fault.
  always_comb begin
    misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  end
  assign err = illegal | misalign;
`else
  assign err = illegal;
`endif

  // Next-state logic: accept in IDLE, count in WAIT, produce response from RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 3'(WAIT_STATES - 1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err;
        rsp_rdata_d = (we_q || err) ? '0 : ld_val;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Store commit on the RESP edge, enabled bytes only; the array is never reset.
  always_ff @(posedge clk) begin
    if (state_q == RESP && we_q && !err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: two instances (WAIT_STATES 0 and 3) share a
// byte-level reference memory model; a negedge monitor checks every response.
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NB    = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq0[$];
  exp_t        sbq1[$];
  logic [7:0]  mref [2][NB];
  logic [31:0] last_rd [2];
  logic        last_err[2];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc++;

  function automatic int ws(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic void check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (dut%0d): got %h expected %h at cycle %0d", name, i, act, exp, cyc);
    end
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? sbq0.size() : sbq1.size();
  endfunction

  function automatic void qpush(input int i, input exp_t e);
    if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
  endfunction

  function automatic exp_t qpop(input int i);
    return (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
  endfunction

  // Reference: RV32I access semantics over a flat byte array with address wrap.
  function automatic void model(input int i, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int unsigned n = 0;
    bit          sgn = 0;
    bit          legal = 1;
    int unsigned base;
    logic [31:0] v;
    rd  = '0;
    err = 1'b0;
    case (f3)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: begin n = 4; end
      3'd4: begin n = 1; legal = !we; end
      3'd5: begin n = 2; legal = !we; end
      default: legal = 0;
    endcase
    if (!legal) begin
      err = 1'b1;
      return;
    end
    base = a % NB;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (base % n != 0) begin
      err = 1'b1;
      return;
    end
`endif
    base = base - (base % n);
    if (we) begin
      for (int unsigned k = 0; k < n; k++) mref[i][base + k] = wd[8*k +: 8];
    end else begin
      v = '0;
      for (int unsigned k = 0; k < n; k++) v = v | (32'(mref[i][base + k]) << (8 * k));
      if (sgn && n < 4 && v[8*n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      rd = v;
    end
  endfunction

  // Monitor: pop and compare on every response pulse; check hold while idle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n[i]) begin
        if (rsp_valid[i]) begin
          if (qsize(i) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp (dut%0d): got rsp_valid 1 expected no response at cycle %0d", i, cyc);
          end else begin
            exp_t e;
            e = qpop(i);
            check("rsp_rdata", i, rsp_rdata[i], e.rdata);
            check("rsp_err", i, 32'(rsp_err[i]), 32'(e.err));
            check("rsp_latency", i, 32'(cyc), 32'(e.cyc));
          end
          last_rd[i]  = rsp_rdata[i];
          last_err[i] = rsp_err[i];
        end else begin
          check("hold_rdata", i, rsp_rdata[i], last_rd[i]);
          check("hold_err", i, 32'(rsp_err[i]), 32'(last_err[i]));
        end
      end
    end
  end

  // Issue one request, push its expectation, then check req_ready through the busy window.
  task automatic issue(input int i, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input bit poke);
    bit          got = 0;
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout (dut%0d): got req_ready 0 expected 1 within 20 cycles", i);
      return;
    end
    req_valid[i]  = 1'b1;
    req_we[i]     = we;
    req_funct3[i] = f3;
    req_addr[i]   = a;
    req_wdata[i]  = wd;
    model(i, we, f3, a, wd, rd, er);
    e.rdata = rd;
    e.err   = er;
    e.cyc   = cyc + 2 + ws(i);
    qpush(i, e);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    for (int k = 0; k <= ws(i); k++) begin
      @(negedge clk);
      check("ready_busy", i, 32'(req_ready[i]), 32'd0);
      if (poke) begin
        req_valid[i]  = 1'b1;
        req_we[i]     = 1'b1;
        req_funct3[i] = 3'd2;
        req_addr[i]   = $urandom;
        req_wdata[i]  = $urandom;
      end
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
    check("ready_idle", i, 32'(req_ready[i]), 32'd1);
  endtask

  task automatic check_reset_outputs(input int i);
    check("rst_ready", i, 32'(req_ready[i]), 32'd1);
    check("rst_valid", i, 32'(rsp_valid[i]), 32'd0);
    check("rst_rdata", i, rsp_rdata[i], 32'd0);
    check("rst_err", i, 32'(rsp_err[i]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < int'(NB); b++) mref[i][b] = (b % 4 == 0) ? 8'h08 : 8'h00;
      rst_n[i]      = 1'b0;
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_funct3[i] = '0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
      last_rd[i]    = '0;
      last_err[i]   = 1'b0;
    end
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Initial contents and WAIT_STATES=3 latency.
    issue(1, 1'b0, 3'd2, 32'h0000_0000, 32'h0, 1'b1);

    // Word store/load, byte stores, sign/zero extension.
    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    issue(0, 1'b1, 3'd0, 32'h11, 32'h7F, 1'b0);
    issue(0, 1'b0, 3'd0, 32'h11, 32'h0, 1'b0);
    issue(0, 1'b1, 3'd0, 32'h12, 32'h80, 1'b1);
    issue(0, 1'b0, 3'd0, 32'h12, 32'h0, 1'b0);
    issue(0, 1'b0, 3'd4, 32'h12, 32'h0, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);

    // Address wrap and illegal funct3 leaving memory untouched.
    issue(0, 1'b1, 3'd2, 32'h100, 32'h1234, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    issue(0, 1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue(0, 1'b1, 3'd4, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);

    // Misaligned half store then unsigned half load.
    issue(0, 1'b1, 3'd1, 32'h21, 32'hABCD, 1'b0);
    issue(0, 1'b0, 3'd5, 32'h20, 32'h0, 1'b0);

    // Reset during the second WAIT cycle aborts an uncommitted store.
    begin
      bit got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (req_ready[1]) got = 1;
      end
      if (!got) begin
        tests++;
        fails++;
        $display("FAIL abort_ready_timeout (dut1): got req_ready 0 expected 1");
      end
      req_valid[1]  = 1'b1;
      req_we[1]     = 1'b1;
      req_funct3[1] = 3'd2;
      req_addr[1]   = 32'h44;
      req_wdata[1]  = 32'hCAFE_F00D;
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n[1] = 1'b0;
      #1;
      check_reset_outputs(1);
      last_rd[1]  = '0;
      last_err[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n[1] = 1'b1;
      repeat (8) @(negedge clk);
      issue(1, 1'b0, 3'd2, 32'h44, 32'h0, 1'b0);
    end

    // Randomized traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      int          i;
      logic [31:0] a;
      i = n % 2;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = (a & 32'hFFFF_FF00) | 32'($urandom_range(0, 31));
      issue(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            1'($urandom_range(0, 1)));
    end

    begin
      int t = 0;
      while ((qsize(0) != 0 || qsize(1) != 0) && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (qsize(0) != 0 || qsize(1) != 0) begin
        tests++;
        fails++;
        $display("FAIL drain: got %0d/%0d pending responses expected 0", qsize(0), qsize(1));
      end
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
